// File: rtl/board_io_ctrl.sv
// Board-level I/O front-end: lock-qualified core reset, debounced buttons with
// sticky press IRQs, synchronised switches and PWM-dimmed LED outputs.
module board_io_ctrl #(
    parameter int BTN_NUM         = 5,
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_STRETCH     = 16,
    parameter int PWM_BITS        = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 pll_locked_i,
    input  logic [BTN_NUM-1:0]   btn_i,
    input  logic [SW_WIDTH-1:0]  sw_i,
    input  logic [LED_WIDTH-1:0] led_i,
    input  logic [PWM_BITS-1:0]  led_bright_i,
    input  logic [BTN_NUM-1:0]   irq_ack_i,
    output logic                 sys_rst_o,
    output logic [SW_WIDTH-1:0]  sw_o,
    output logic [BTN_NUM-1:0]   btn_level_o,
    output logic [BTN_NUM-1:0]   btn_press_o,
    output logic [BTN_NUM-1:0]   btn_irq_o,
    output logic [LED_WIDTH-1:0] led_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(RST_STRETCH + 1);

    logic                 lock_meta_r;
    logic                 lock_sync_r;
    logic [BTN_NUM-1:0]   btn_meta_r;
    logic [BTN_NUM-1:0]   btn_sync_r;
    logic [SW_WIDTH-1:0]  sw_meta_r;
    logic [SW_WIDTH-1:0]  sw_sync_r;
    logic [RW-1:0]        rcnt_r;
    logic                 sys_rst_r;
    logic [DW-1:0]        dcnt_r [BTN_NUM];
    logic [BTN_NUM-1:0]   level_r;
    logic [BTN_NUM-1:0]   level_prev_r;
    logic [BTN_NUM-1:0]   press_r;
    logic [BTN_NUM-1:0]   irq_r;
    logic [PWM_BITS-1:0]  pcnt_r;
    logic [LED_WIDTH-1:0] led_r;
    logic                 pwm_en_s;

    // Two-flop synchronisers for every asynchronous board input.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
            btn_meta_r  <= '0;
            btn_sync_r  <= '0;
            sw_meta_r   <= '0;
            sw_sync_r   <= '0;
        end else begin
            lock_meta_r <= pll_locked_i;
            lock_sync_r <= lock_meta_r;
            btn_meta_r  <= btn_i;
            btn_sync_r  <= btn_meta_r;
            sw_meta_r   <= sw_i;
            sw_sync_r   <= sw_meta_r;
        end
    end

    // Reset stretcher: any unlocked cycle restarts the full release count.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rcnt_r    <= '0;
            sys_rst_r <= 1'b1;
        end else if (!lock_sync_r) begin
            rcnt_r    <= '0;
            sys_rst_r <= 1'b1;
        end else if (rcnt_r != RW'(RST_STRETCH)) begin
            rcnt_r <= rcnt_r + RW'(1);
            if (rcnt_r == RW'(RST_STRETCH - 1)) begin
                sys_rst_r <= 1'b0;
            end
        end
    end

    // Per-channel debouncers; they keep running while the core is in reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < BTN_NUM; i++) begin
                dcnt_r[i] <= '0;
            end
            level_r <= '0;
        end else begin
            for (int i = 0; i < BTN_NUM; i++) begin
                if (btn_sync_r[i] == level_r[i]) begin
                    dcnt_r[i] <= '0;
                end else if (dcnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    dcnt_r[i]  <= '0;
                    level_r[i] <= ~level_r[i];
                end else begin
                    dcnt_r[i] <= dcnt_r[i] + DW'(1);
                end
            end
        end
    end

    // Rising-edge press pulses and sticky IRQ flags; a press beats a same-cycle ack.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            level_prev_r <= '0;
            press_r      <= '0;
            irq_r        <= '0;
        end else begin
            level_prev_r <= level_r;
            if (sys_rst_r) begin
                press_r <= '0;
                irq_r   <= '0;
            end else begin
                press_r <= level_r & ~level_prev_r;
                irq_r   <= (irq_r & ~irq_ack_i) | press_r;
            end
        end
    end

    // PWM enable: full brightness bypasses the compare to reach 100% duty.
    always_comb begin
        pwm_en_s = 1'b0;
        if (led_bright_i == {PWM_BITS{1'b1}}) begin
            pwm_en_s = 1'b1;
        end else if (pcnt_r < led_bright_i) begin
            pwm_en_s = 1'b1;
        end else begin
            pwm_en_s = 1'b0;
        end
    end

    // Free-running PWM counter and registered LED drive.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pcnt_r <= '0;
            led_r  <= '0;
        end else begin
            pcnt_r <= pcnt_r + PWM_BITS'(1);
            led_r  <= led_i & {LED_WIDTH{pwm_en_s}};
        end
    end

    assign sys_rst_o   = sys_rst_r;
    assign sw_o        = sw_sync_r;
    assign btn_level_o = level_r;
    assign btn_press_o = press_r;
    assign btn_irq_o   = irq_r;
    assign led_o       = led_r;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with short debounce, reset stretch and PWM width.
module tb_board_io_ctrl;

    localparam int BTN_NUM = 5;
    localparam int SW_W    = 16;
    localparam int LED_W   = 16;
    localparam int PWM_B   = 4;

    logic              clk;
    logic              arst_n;
    logic              pll_locked;
    logic [BTN_NUM-1:0] btn;
    logic [SW_W-1:0]   sw;
    logic [LED_W-1:0]  led_in;
    logic [PWM_B-1:0]  bright;
    logic [BTN_NUM-1:0] ack;
    logic              sys_rst;
    logic [SW_W-1:0]   sw_out;
    logic [BTN_NUM-1:0] level;
    logic [BTN_NUM-1:0] press;
    logic [BTN_NUM-1:0] irq;
    logic [LED_W-1:0]  led_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    board_io_ctrl #(
        .BTN_NUM(BTN_NUM), .SW_WIDTH(SW_W), .LED_WIDTH(LED_W),
        .DEBOUNCE_CYCLES(4), .RST_STRETCH(8), .PWM_BITS(PWM_B)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .pll_locked_i(pll_locked),
        .btn_i(btn), .sw_i(sw), .led_i(led_in), .led_bright_i(bright),
        .irq_ack_i(ack), .sys_rst_o(sys_rst), .sw_o(sw_out),
        .btn_level_o(level), .btn_press_o(press), .btn_irq_o(irq), .led_o(led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until sys_rst equals want; returns 99 if the budget expires.
    task automatic wait_rst(input logic want, output int n);
        n = 99;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (sys_rst === want) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        arst_n = 1'b0; pll_locked = 1'b1; btn = '0; sw = '0;
        led_in = '0; bright = '0; ack = '0;
        tick(); tick();
        vec_cnt++;
        if (sys_rst !== 1'b1 || sw_out !== 16'h0000 || level !== 5'b0 ||
            press !== 5'b0 || irq !== 5'b0 || led_out !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_values: rst=%b sw=%h lvl=%b prs=%b irq=%b led=%h, want 1/0/0/0/0/0",
                     sys_rst, sw_out, level, press, irq, led_out);
        end
        arst_n = 1'b1;
        wait_rst(1'b0, n);
        vec_cnt++;
        if (n !== 10) begin
            err_cnt++;
            $display("FAIL reset_release: released after %0d cycles, want 10", n);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_rst(1'b0, n);
        vec_cnt++;
        if (n !== 10) begin
            err_cnt++;
            $display("FAIL lock_loss_midcount: released %0d cycles after drop, want 11", n + 1);
        end
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_rst(1'b1, n);
        vec_cnt++;
        if (n !== 2) begin
            err_cnt++;
            $display("FAIL lock_loss_reassert: reasserted %0d cycles after drop, want 3", n + 1);
        end
        wait_rst(1'b0, n);
        vec_cnt++;
        if (n !== 8) begin
            err_cnt++;
            $display("FAIL lock_loss_restretch: released after %0d cycles, want 8", n);
        end
    endtask

    task automatic test_debounce();
        int bad;
        int rise_at;
        int press_n;
        int press_at;
        bad = 0;
        btn[0] = 1'b1;
        tick(); tick(); tick();
        btn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (level[0] !== 1'b0 || press[0] !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0) begin
            err_cnt++;
            $display("FAIL glitch_reject: %0d cycles with level/press set, want 0", bad);
        end
        rise_at = 0; press_n = 0; press_at = 0;
        btn[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (level[0] === 1'b1 && rise_at == 0) rise_at = k;
            if (press[0] === 1'b1) begin
                press_n++;
                press_at = k;
            end
        end
        vec_cnt++;
        if (rise_at !== 6) begin
            err_cnt++;
            $display("FAIL debounce_latency: level rose at cycle %0d, want 6", rise_at);
        end
        vec_cnt++;
        if (press_n !== 1 || press_at !== 7) begin
            err_cnt++;
            $display("FAIL press_pulse: %0d pulses at cycle %0d, want 1 at 7", press_n, press_at);
        end
        vec_cnt++;
        if (irq !== 5'b00001) begin
            err_cnt++;
            $display("FAIL irq_set: irq=%b, want 00001", irq);
        end
        bad = 0;
        btn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (press !== 5'b0) bad++;
        end
        vec_cnt++;
        if (bad !== 0 || level !== 5'b0 || irq !== 5'b00001) begin
            err_cnt++;
            $display("FAIL release: press_cycles=%0d lvl=%b irq=%b, want 0/00000/00001", bad, level, irq);
        end
    endtask

    task automatic test_irq();
        btn[1:0] = 2'b11;
        for (int k = 0; k < 7; k++) tick();
        vec_cnt++;
        if (press !== 5'b00011) begin
            err_cnt++;
            $display("FAIL press_both: press=%b, want 00011", press);
        end
        ack = 5'b00001;
        tick();
        ack = 5'b00000;
        vec_cnt++;
        if (irq !== 5'b00011) begin
            err_cnt++;
            $display("FAIL irq_set_wins: irq=%b, want 00011", irq);
        end
        ack = 5'b00001;
        tick();
        ack = 5'b00000;
        vec_cnt++;
        if (irq !== 5'b00010) begin
            err_cnt++;
            $display("FAIL irq_ack: irq=%b, want 00010", irq);
        end
        btn = '0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    // Run 16 consecutive cycles and count full-on and illegal LED values.
    task automatic pwm_window(input logic [LED_W-1:0] pat, input logic [PWM_B-1:0] b,
                              output int on_n, output int odd_n);
        led_in = pat; bright = b;
        tick();
        on_n = 0; odd_n = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (led_out === pat) on_n++;
            else if (led_out !== 16'h0000) odd_n++;
        end
    endtask

    task automatic test_pwm();
        int on_n;
        int odd_n;
        pwm_window(16'hFFFF, 4'd4, on_n, odd_n);
        vec_cnt++;
        if (on_n !== 4 || odd_n !== 0) begin
            err_cnt++;
            $display("FAIL pwm_quarter: on=%0d odd=%0d, want 4/0", on_n, odd_n);
        end
        pwm_window(16'hFFFF, 4'd0, on_n, odd_n);
        vec_cnt++;
        if (on_n !== 0 || odd_n !== 0) begin
            err_cnt++;
            $display("FAIL pwm_off: on=%0d odd=%0d, want 0/0", on_n, odd_n);
        end
        pwm_window(16'h1234, 4'd15, on_n, odd_n);
        vec_cnt++;
        if (on_n !== 16 || odd_n !== 0) begin
            err_cnt++;
            $display("FAIL pwm_full: on=%0d odd=%0d, want 16/0", on_n, odd_n);
        end
    endtask

    task automatic test_switches();
        sw = 16'hA5A5;
        tick();
        vec_cnt++;
        if (sw_out !== 16'h0000) begin
            err_cnt++;
            $display("FAIL sw_early: sw_o=%h after 1 cycle, want 0000", sw_out);
        end
        tick();
        vec_cnt++;
        if (sw_out !== 16'hA5A5) begin
            err_cnt++;
            $display("FAIL sw_sync: sw_o=%h after 2 cycles, want a5a5", sw_out);
        end
        led_in = 16'hFFFF; bright = 4'd15; btn = 5'b00100;
        for (int k = 0; k < 8; k++) tick();
        arst_n = 1'b0;
        #1;
        vec_cnt++;
        if (sw_out !== 16'h0000 || sys_rst !== 1'b1 || level !== 5'b0 ||
            irq !== 5'b0 || led_out !== 16'h0000) begin
            err_cnt++;
            $display("FAIL async_reset: sw=%h rst=%b lvl=%b irq=%b led=%h, want 0/1/0/0/0",
                     sw_out, sys_rst, level, irq, led_out);
        end
    endtask

    initial begin
        test_reset();
        test_lock_loss();
        test_debounce();
        test_irq();
        test_pwm();
        test_switches();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
